// File: rtl/rv64g_pkg.sv
// ---------------------------------------------------------------------------
// rv64g_pkg -- shared constants and types for the RV64G front end.
//
// Contents:
//   XLEN         default address width (64)
//   BRU_DEPTH    default depth of the branch resolve unit prediction queue
//   BRU_CNT_MAX  saturation value of the mispredict statistics counter
//   bru_entry_t  one in-flight prediction: word-aligned pc and predicted next
// ---------------------------------------------------------------------------
package rv64g_pkg;

    localparam int XLEN      = 64;
    localparam int BRU_DEPTH = 8;

    localparam logic [31:0] BRU_CNT_MAX = 32'hFFFF_FFFF;

    // Only bits [XLEN-1:2] are kept: instructions are word aligned, so the
    // two low bits carry no information for prediction checking.
    typedef struct packed {
        logic [XLEN-1:2] pc;
        logic [XLEN-1:2] next;
    } bru_entry_t;

endpackage : rv64g_pkg

// File: rtl/bru_pred_queue.sv
// ---------------------------------------------------------------------------
// bru_pred_queue -- circular FIFO of in-flight branch predictions.
//
// Parameters:
//   W      entry width in bits
//   DEPTH  number of entries, power of two, at least 2
//
// Ports:
//   clk        clock, all state updated on the rising edge
//   rst_n      synchronous active-low reset (clears pointers and count)
//   push       write push_data at the tail (ignored when full)
//   push_data  entry to append
//   pop        drop the head entry (ignored when empty)
//   flush      discard every entry; overrides push and pop in that cycle
//   occupancy  number of stored entries, 0..DEPTH
//   head       oldest entry (undefined content when occupancy is 0)
//
// Storage is not reset; validity is tracked by the pointers and the count.
// ---------------------------------------------------------------------------
module bru_pred_queue #(
    parameter int W     = 124,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [W-1:0]               head
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH+1);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("bru_pred_queue: DEPTH must be a power of two and at least 2");
    end

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [OW-1:0] count;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push && (count != OW'(DEPTH));
    assign pop_ok  = pop && (count != '0);

    // DEPTH is a power of two, so natural PW-bit overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign occupancy = count;
    assign head      = mem[rd_ptr];

endmodule : bru_pred_queue

// File: rtl/branch_resolve_unit.sv
// ---------------------------------------------------------------------------
// branch_resolve_unit -- checks fetch-time next-address predictions against
// execute-time resolutions and requests a flush plus BTB update on mismatch.
//
// Configuration macro:
//   BRU_MISPREDICT_STATS_EN  when defined, mispredict_count_o is a saturating
//                            count of mispredicting pops; otherwise it is 0
//                            and no counter is built.
//
// Parameters:
//   XLEN   address width
//   DEPTH  in-flight prediction queue depth (power of two, >= 2)
//
// Ports:
//   clk_i               clock
//   arst_ni             synchronous active-low reset
//   pred_valid_i/pred_pc_i/pred_next_i/pred_ready_o   prediction from fetch
//   res_valid_i/res_pc_i/res_next_i/res_is_jump_i/res_ready_o
//                       resolution of the oldest instruction from execute
//   btb_upd_valid_o/btb_upd_curr_o/btb_upd_next_o/btb_upd_jump_o
//                       one-cycle BTB write request
//   pipeline_clear_o    one-cycle flush request
//   redirect_pc_o       correct fetch address while pipeline_clear_o is high
//   occupancy_o         queued entries
//   mispredict_count_o  mispredict statistics
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready never depends on valid in the same cycle; valid may be
// asserted or dropped freely while ready is low and no transfer occurs.
// ---------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int XLEN  = rv64g_pkg::XLEN,
    parameter int DEPTH = rv64g_pkg::BRU_DEPTH
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       pred_valid_i,
    input  logic [XLEN-1:0]            pred_pc_i,
    input  logic [XLEN-1:0]            pred_next_i,
    output logic                       pred_ready_o,
    input  logic                       res_valid_i,
    input  logic [XLEN-1:0]            res_pc_i,
    input  logic [XLEN-1:0]            res_next_i,
    input  logic                       res_is_jump_i,
    output logic                       res_ready_o,
    output logic                       btb_upd_valid_o,
    output logic [XLEN-1:0]            btb_upd_curr_o,
    output logic [XLEN-1:0]            btb_upd_next_o,
    output logic                       btb_upd_jump_o,
    output logic                       pipeline_clear_o,
    output logic [XLEN-1:0]            redirect_pc_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [31:0]                mispredict_count_o
);

    localparam int OW = $clog2(DEPTH+1);
    localparam int AW = XLEN - 2;

    // Same layout as rv64g_pkg::bru_entry_t, sized by this instance's XLEN.
    typedef struct packed {
        logic [XLEN-1:2] pc;
        logic [XLEN-1:2] next;
    } entry_t;

    entry_t        push_entry;
    entry_t        head_entry;
    logic [OW-1:0] occupancy;
    logic          push_fire;
    logic          pop_fire;
    logic          mispredict;

    logic            clear_q;
    logic            upd_valid_q;
    logic [AW-1:0]   upd_curr_q;
    logic [AW-1:0]   upd_next_q;
    logic            upd_jump_q;

    // Both readies come only from registered state. Blocking pushes while a
    // clear is on the wire keeps wrong-path predictions out of the queue.
    assign pred_ready_o = (occupancy < OW'(DEPTH)) && !clear_q;
    assign res_ready_o  = (occupancy != '0);

    assign push_fire = pred_valid_i && pred_ready_o;
    assign pop_fire  = res_valid_i && res_ready_o;

    assign push_entry.pc   = pred_pc_i[XLEN-1:2];
    assign push_entry.next = pred_next_i[XLEN-1:2];

    assign mispredict = pop_fire &&
                        ((head_entry.next != res_next_i[XLEN-1:2]) ||
                         (head_entry.pc   != res_pc_i[XLEN-1:2]));

    // A mispredict flushes the queue at the same edge, which also drops any
    // push presented in that cycle (flush has priority inside the queue).
    bru_pred_queue #(
        .W     ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk_i),
        .rst_n     (arst_ni),
        .push      (push_fire),
        .push_data (push_entry),
        .pop       (pop_fire),
        .flush     (mispredict),
        .occupancy (occupancy),
        .head      (head_entry)
    );

    // Clear and update strobes last exactly one cycle; the address fields
    // hold their last value, which is only meaningful alongside the strobes.
    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            clear_q     <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_curr_q  <= '0;
            upd_next_q  <= '0;
            upd_jump_q  <= 1'b0;
        end else begin
            clear_q     <= mispredict;
            upd_valid_q <= mispredict;
            if (mispredict) begin
                upd_curr_q <= res_pc_i[XLEN-1:2];
                upd_next_q <= res_next_i[XLEN-1:2];
                upd_jump_q <= res_is_jump_i;
            end
        end
    end

    assign pipeline_clear_o = clear_q;
    assign redirect_pc_o    = {upd_next_q, 2'b00};
    assign btb_upd_valid_o  = upd_valid_q;
    assign btb_upd_curr_o   = {upd_curr_q, 2'b00};
    assign btb_upd_next_o   = {upd_next_q, 2'b00};
    assign btb_upd_jump_o   = upd_jump_q;
    assign occupancy_o      = occupancy;

`ifdef BRU_MISPREDICT_STATS_EN
    logic [31:0] mp_count_q;

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            mp_count_q <= '0;
        end else if (mispredict && (mp_count_q != rv64g_pkg::BRU_CNT_MAX)) begin
            mp_count_q <= mp_count_q + 32'd1;
        end
    end

    assign mispredict_count_o = mp_count_q;
`else
    assign mispredict_count_o = 32'd0;
`endif

    // Byte-offset bits of every address input are architecturally zero and
    // deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{pred_pc_i[1:0], pred_next_i[1:0],
                                res_pc_i[1:0], res_next_i[1:0]};

endmodule : branch_resolve_unit

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
- REQ-001 SHALL take parameter XLEN, default rv64g_pkg::XLEN (64), the address width.
- REQ-002 SHALL take parameter DEPTH, default rv64g_pkg::BRU_DEPTH (8), the in-flight prediction queue depth; it SHALL be a power of two and at least 2.
- REQ-003 clk_i  input  1  sole clock, all state updated on its rising edge.
- REQ-004 arst_ni  input  1  reset, synchronous and active-low.
- REQ-005 pred_valid_i  input  1  fetch presents a prediction.
- REQ-006 pred_pc_i  input  XLEN  fetched instruction address.
- REQ-007 pred_next_i  input  XLEN  predicted next address, as supplied by the branch target buffer.
- REQ-008 pred_ready_o  output  1  queue accepts a prediction.
- REQ-009 res_valid_i  input  1  execute presents the resolution of the oldest instruction.
- REQ-010 res_pc_i  input  XLEN  resolved instruction address.
- REQ-011 res_next_i  input  XLEN  actual next address.
- REQ-012 res_is_jump_i  input  1  resolved instruction is a jump or branch.
- REQ-013 res_ready_o  output  1  an entry is available to resolve.
- REQ-014 btb_upd_valid_o  output  1  one-cycle write request to the branch target buffer.
- REQ-015 btb_upd_curr_o  output  XLEN  update tag address.
- REQ-016 btb_upd_next_o  output  XLEN  update target address.
- REQ-017 btb_upd_jump_o  output  1  update is for a jump or branch.
- REQ-018 pipeline_clear_o  output  1  one-cycle flush request.
- REQ-019 redirect_pc_o  output  XLEN  correct fetch address, valid while pipeline_clear_o is high.
- REQ-020 occupancy_o  output  $clog2(DEPTH+1)  number of queued entries.
- REQ-021 mispredict_count_o  output  32  mispredict count, see REQ-036.

Function
- REQ-022 SHALL store only address bits [XLEN-1:2]; all compares SHALL use bits [XLEN-1:2]; address outputs SHALL drive bits [1:0] as zero.
- REQ-023 SHALL push an entry on a cycle with pred_valid_i & pred_ready_o, and pop the oldest entry on a cycle with res_valid_i & res_ready_o.
- REQ-024 pred_ready_o SHALL be (occupancy < DEPTH) & ~pipeline_clear_o; a full queue SHALL NOT accept a push even when a pop occurs in the same cycle.
- REQ-025 res_ready_o SHALL be occupancy != 0; res_valid_i SHALL be ignored when the queue is empty.
- REQ-026 A popped entry SHALL mispredict if its stored next address differs from res_next_i, or its stored pc differs from res_pc_i.
- REQ-027 On a mispredicting pop, in the next cycle only: pipeline_clear_o=1, redirect_pc_o=res_next_i, btb_upd_valid_o=1, btb_upd_curr_o=res_pc_i, btb_upd_next_o=res_next_i, btb_upd_jump_o=res_is_jump_i.
- REQ-028 A mispredicting pop SHALL empty the queue at the same edge (occupancy 0); a push in that cycle SHALL be discarded.
- REQ-029 A correctly predicted pop SHALL produce no clear and no update.
- REQ-030 Read and write pointers SHALL wrap modulo DEPTH; a simultaneous push and pop SHALL leave occupancy unchanged.
- REQ-031 Latency from a resolving pop to the clear/update outputs SHALL be exactly 1 cycle; all outputs SHALL be registered or derived only from registered state.

Reset
- REQ-032 While arst_ni=0 at a clock edge, the block SHALL clear pointers, set occupancy_o=0, and clear pipeline_clear_o and btb_upd_valid_o.
- REQ-033 Reset SHALL set redirect_pc_o, btb_upd_*_o and mispredict_count_o to 0.
- REQ-034 Reset asserted mid-operation SHALL discard all queued entries and any pending clear or update.
- REQ-035 Queue storage contents need not be reset.

Configuration
- REQ-036 With macro BRU_MISPREDICT_STATS_EN defined, mispredict_count_o SHALL increment by one per mispredicting pop and saturate at 32'hFFFF_FFFF.
- REQ-037 Without BRU_MISPREDICT_STATS_EN, mispredict_count_o SHALL be constant 0 and no counter logic SHALL be synthesised.

Structure
- REQ-038 rv64g_pkg SHALL hold BRU_DEPTH and typedef bru_entry_t {pc[XLEN-1:2], next[XLEN-1:2]}.
- REQ-039 The queue SHALL be a sub-module bru_pred_queue, with push, pop, flush, occupancy and head outputs.

Verification
- REQ-040 Push pc=0x1000/next=0x1004, then resolve next=0x1004 -> no clear, no update, occupancy 1->0.
- REQ-041 Push pc=0x2000/next=0x2004 plus 3 younger entries, then resolve next=0x3000 jump=1 -> next cycle: clear=1, redirect=0x3000, update (0x2000,0x3000,1), occupancy 0.
- REQ-042 Push 8 entries -> pred_ready_o=0; push+pop in the same cycle -> no push accepted, occupancy 7.
- REQ-043 Push 20 entries with matching resolutions interleaved -> pointers wrap and FIFO order is preserved.
- REQ-044 Assert arst_ni=0 with 5 entries queued and a mispredict pop in the same cycle -> next cycle: occupancy 0, clear=0, upd_valid=0.
- REQ-045 With BRU_MISPREDICT_STATS_EN defined, 3 mispredicts -> count=3; without it, count=0.
